// File: rtl/ifetch_queue.sv
// Fetch queue between the PC register and decode: drives the PC into a 1-cycle instruction
// memory, buffers returned words with their PC, and stalls the PC when full. Option: IFQ_BYPASS_EN.
module ifetch_queue_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             push_i,
    input logic [CNT_W-1:0] count_i
);
    // A returning word must never land on a full queue; the hold logic prevents it.
    a_no_push_on_full: assert property (@(posedge clk) disable iff (reset)
        !(push_i && (count_i == CNT_W'(DEPTH))));
endmodule

module ifetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_jump_en,
    output logic [ADDR_W-1:0]  pc_jump_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_req,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] word_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inflight_valid_q, inflight_valid_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic               bypass_s;
    logic               pop_s;
    logic               fifo_pop_s;
    logic               push_s;
    logic               hold_s;
    logic [CNT_W-1:0]   occupancy_s;

    // Handshake, hold/redirect decision and queue next-state.
    always_comb begin
        bypass_s    = 1'b0;
        instr_out   = word_mem_q[rd_ptr_q];
        instr_pc    = pc_mem_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
        bypass_s = (count_q == '0) && inflight_valid_q && !branch_req && !reset;
        if (bypass_s) begin
            instr_out = imem_rdata;
            instr_pc  = inflight_pc_q;
        end else begin
            instr_out = word_mem_q[rd_ptr_q];
            instr_pc  = pc_mem_q[rd_ptr_q];
        end
`endif
        instr_valid = !reset && ((count_q != '0) || bypass_s);
        pop_s       = instr_valid && instr_ready;
        fifo_pop_s  = pop_s && !bypass_s;
        // A bypassed word that decode takes this cycle never enters the queue.
        push_s      = inflight_valid_q && !branch_req && !(bypass_s && instr_ready);

        // Slots already committed after this cycle: queued, minus leaving, plus returning.
        occupancy_s = count_q + CNT_W'(inflight_valid_q) - CNT_W'(pop_s);
        hold_s      = (occupancy_s >= DEPTH_C);

        imem_addr   = pc_in;
        pc_jump_en  = !reset && (branch_req || hold_s);
        if (branch_req) begin
            pc_jump_addr = branch_target;
        end else begin
            pc_jump_addr = pc_in;
        end

        inflight_valid_d = !branch_req && !hold_s;
        inflight_pc_d    = pc_in;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (branch_req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (fifo_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(fifo_pop_s);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
        end
    end

    // Queue storage; contents are meaningful only below count_q.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            word_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    ifetch_queue_chk #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .count_i (count_q)
    );
endmodule
